// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch port and the data port.
// Define MEM_ARB_RR_EN for round-robin grant on ties; by default the data port always wins.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              grant_d_s;

`ifdef MEM_ARB_RR_EN
  // rr_last: 0 = data port served last, 1 = fetch port served last
  logic              rr_last_q, rr_last_d;
  assign grant_d_s = d_req & ~(if_req & ~rr_last_q);
`else
  assign grant_d_s = d_req;
`endif

  // Next-state and registered-output computation for the arbitration FSM
  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
`ifdef MEM_ARB_RR_EN
    rr_last_d  = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (grant_d_s) begin
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          state_d   = BUSY_D;
`ifdef MEM_ARB_RR_EN
          rr_last_d = 1'b0;
`endif
        end else if (if_req) begin
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          state_d   = BUSY_IF;
`ifdef MEM_ARB_RR_EN
          rr_last_d = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (m_ready) begin
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = IDLE;
          if (state_q == BUSY_D) begin
            d_valid_d = 1'b1;
            // Stores complete without touching the load-data register
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = m_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          cnt_d   = 8'd0;
          err_d   = 1'b1;
          state_d = IDLE;
          if (state_q == BUSY_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
        m_we_d  = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 8'd0;
`ifdef MEM_ARB_RR_EN
      rr_last_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q  <= rr_last_d;
`endif
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign err       = err_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_req & ~d_valid_q;

endmodule
